wb_port_arbiter: RTL and testbench

Shares the single register-file write port between the MEM/WB pipeline register and the multi-cycle M-extension unit (divider/long multiply). Sits after the MEM/WB register: it selects the writeback data, buffers one long-unit result, and freezes MEM/WB through a stall output when a buffered result has waited too long. Guarantees one register-file write per cycle, never a write to x0, and bounded latency for long-unit results.

---
 rtl/wb_port_arbiter_if.sv | 35 +++
 rtl/wb_port_arbiter.sv | 116 +++++++++++
 tb/tb_wb_port_arbiter.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/wb_port_arbiter_if.sv
// Writeback-port bundle: MEM/WB pipeline writeback, long-unit result handshake,
// register-file write port and the freeze request back to the pipeline.
`ifndef DATAWIDTH
`define DATAWIDTH 32
`endif

interface wb_port_arbiter_if;
  logic                  pipe_RegWrite;
  logic                  pipe_MemtoReg;
  logic [4:0]            pipe_rd;
  logic [`DATAWIDTH-1:0] pipe_MemData;
  logic [`DATAWIDTH-1:0] pipe_ALU_result;
  logic                  lu_valid;
  logic [4:0]            lu_rd;
  logic [`DATAWIDTH-1:0] lu_data;
  logic                  lu_ready;
  logic                  rf_we;
  logic [4:0]            rf_waddr;
  logic [`DATAWIDTH-1:0] rf_wdata;
  logic                  stall_o;

  // Environment side: pipeline, long unit and register file.
  modport master (
    output pipe_RegWrite, pipe_MemtoReg, pipe_rd, pipe_MemData, pipe_ALU_result,
    output lu_valid, lu_rd, lu_data,
    input  lu_ready, rf_we, rf_waddr, rf_wdata, stall_o
  );

  // Arbiter side.
  modport slave (
    input  pipe_RegWrite, pipe_MemtoReg, pipe_rd, pipe_MemData, pipe_ALU_result,
    input  lu_valid, lu_rd, lu_data,
    output lu_ready, rf_we, rf_waddr, rf_wdata, stall_o
  );
endinterface

// File: rtl/wb_port_arbiter.sv
// Shares the register-file write port between MEM/WB and the long M-extension unit,
// holding one long-unit result and forcing it through after MAX_WAIT lost cycles.
`ifndef DATAWIDTH
`define DATAWIDTH 32
`endif

module wb_port_arbiter #(
  parameter int MAX_WAIT = 4
) (
  input  logic               clk,
  input  logic               rst,
  wb_port_arbiter_if.slave   bus
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_WAIT  = 2'd1;
  localparam logic [1:0] ST_FORCE = 2'd2;
  localparam logic [3:0] MAX_W4   = 4'(MAX_WAIT);

  logic [1:0]            state_r, state_nxt_s;
  logic [3:0]            cnt_r, cnt_nxt_s;
  logic [4:0]            buf_rd_r;
  logic [`DATAWIDTH-1:0] buf_data_r;
  logic                  buf_valid_s;
  logic                  pipe_wr_s;
  logic [`DATAWIDTH-1:0] pipe_val_s;
  logic                  accept_s;
  logic                  we_s;
  logic [4:0]            waddr_s;
  logic [`DATAWIDTH-1:0] wdata_s;
  logic                  stall_s;

  assign buf_valid_s = (state_r != ST_IDLE);
  assign pipe_wr_s   = bus.pipe_RegWrite && (bus.pipe_rd != 5'd0);
  assign pipe_val_s  = bus.pipe_MemtoReg ? bus.pipe_MemData : bus.pipe_ALU_result;
  // lu_rd == 0 completes the handshake but leaves the buffer empty.
  assign accept_s    = bus.lu_valid && !buf_valid_s && (bus.lu_rd != 5'd0);

  // Write-port selection and next-state decision.
  always_comb begin
    we_s        = pipe_wr_s;
    waddr_s     = bus.pipe_rd;
    wdata_s     = pipe_val_s;
    stall_s     = 1'b0;
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          state_nxt_s = ST_WAIT;
          cnt_nxt_s   = 4'd0;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_WAIT, ST_FORCE: begin
        if (!pipe_wr_s) begin
          we_s        = 1'b1;
          waddr_s     = buf_rd_r;
          wdata_s     = buf_data_r;
          state_nxt_s = ST_IDLE;
          cnt_nxt_s   = 4'd0;
        end else if (bus.pipe_rd == buf_rd_r) begin
          // Younger pipeline write to the same register makes the buffered value dead.
          state_nxt_s = ST_IDLE;
          cnt_nxt_s   = 4'd0;
        end else if (state_r == ST_FORCE) begin
          we_s        = 1'b1;
          waddr_s     = buf_rd_r;
          wdata_s     = buf_data_r;
          stall_s     = 1'b1;
          state_nxt_s = ST_IDLE;
          cnt_nxt_s   = 4'd0;
        end else begin
          cnt_nxt_s   = cnt_r + 4'd1;
          state_nxt_s = ((cnt_r + 4'd1) == MAX_W4) ? ST_FORCE : ST_WAIT;
        end
      end
      default: begin
        we_s        = 1'b0;
        state_nxt_s = ST_IDLE;
        cnt_nxt_s   = 4'd0;
      end
    endcase
  end

  // State, starvation counter and one-entry result buffer.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      cnt_r      <= 4'd0;
      buf_rd_r   <= 5'd0;
      buf_data_r <= '0;
    end else begin
      state_r <= state_nxt_s;
      cnt_r   <= cnt_nxt_s;
      if (accept_s) begin
        buf_rd_r   <= bus.lu_rd;
        buf_data_r <= bus.lu_data;
      end else if (state_nxt_s == ST_IDLE) begin
        buf_rd_r   <= 5'd0;
        buf_data_r <= '0;
      end else begin
        buf_rd_r   <= buf_rd_r;
        buf_data_r <= buf_data_r;
      end
    end
  end

  assign bus.lu_ready = !buf_valid_s;
  assign bus.rf_we    = we_s;
  assign bus.rf_waddr = we_s ? waddr_s : 5'd0;
  assign bus.rf_wdata = we_s ? wdata_s : '0;
  assign bus.stall_o  = stall_s;

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Directed self-checking bench for wb_port_arbiter with MAX_WAIT = 4.
`ifndef DATAWIDTH
`define DATAWIDTH 32
`endif

module tb_wb_port_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  wb_port_arbiter_if bus ();

  wb_port_arbiter #(.MAX_WAIT(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  // Observed vector: {rf_we, rf_waddr, rf_wdata, stall_o, lu_ready}
  logic [`DATAWIDTH+7:0] obs;
  assign obs = {bus.rf_we, bus.rf_waddr, bus.rf_wdata, bus.stall_o, bus.lu_ready};

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_pipe(input logic we, input logic m2r, input logic [4:0] rd,
                          input logic [31:0] mem, input logic [31:0] alu);
    bus.pipe_RegWrite   = we;
    bus.pipe_MemtoReg   = m2r;
    bus.pipe_rd         = rd;
    bus.pipe_MemData    = mem;
    bus.pipe_ALU_result = alu;
    #1;
  endtask

  task automatic set_lu(input logic v, input logic [4:0] rd, input logic [31:0] d);
    bus.lu_valid = v;
    bus.lu_rd    = rd;
    bus.lu_data  = d;
    #1;
  endtask

  function automatic logic [`DATAWIDTH+7:0] exp_v(input logic we, input logic [4:0] a,
                                                  input logic [31:0] d, input logic st,
                                                  input logic rdy);
    return {we, a, d, st, rdy};
  endfunction

  task automatic test_reset();
    logic [`DATAWIDTH+7:0] e;
    rst = 1'b1;
    set_pipe(1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
    set_lu(1'b0, 5'd0, 32'h0);
    tick(); tick();
    rst = 1'b0;
    #1;
    e = exp_v(1'b0, 5'd0, 32'h0, 1'b0, 1'b1);
    total++;
    if (obs !== e) begin bad++; $display("FAIL reset_idle got=%h exp=%h", obs, e); end
    set_pipe(1'b1, 1'b0, 5'd0, 32'h0, 32'h55);
    total++;
    if (obs !== e) begin bad++; $display("FAIL reset_x0_write got=%h exp=%h", obs, e); end
    set_pipe(1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
  endtask

  task automatic test_free_slot();
    logic [`DATAWIDTH+7:0] e;
    set_lu(1'b1, 5'd5, 32'h1234);
    tick();
    set_lu(1'b1, 5'd6, 32'h6666);
    e = exp_v(1'b1, 5'd5, 32'h1234, 1'b0, 1'b0);
    total++;
    if (obs !== e) begin bad++; $display("FAIL free_slot_write got=%h exp=%h", obs, e); end
    tick();
    set_lu(1'b0, 5'd0, 32'h0);
    e = exp_v(1'b0, 5'd0, 32'h0, 1'b0, 1'b1);
    total++;
    if (obs !== e) begin bad++; $display("FAIL free_slot_no_reaccept got=%h exp=%h", obs, e); end
    tick();
    total++;
    if (obs !== e) begin bad++; $display("FAIL free_slot_idle got=%h exp=%h", obs, e); end
  endtask

  task automatic test_drop_x0();
    logic [`DATAWIDTH+7:0] e;
    set_lu(1'b1, 5'd0, 32'h9999);
    tick();
    set_lu(1'b0, 5'd0, 32'h0);
    e = exp_v(1'b0, 5'd0, 32'h0, 1'b0, 1'b1);
    total++;
    if (obs !== e) begin bad++; $display("FAIL drop_x0 got=%h exp=%h", obs, e); end
  endtask

  task automatic test_starvation();
    logic [`DATAWIDTH+7:0] e;
    set_lu(1'b1, 5'd7, 32'h77);
    tick();
    set_lu(1'b0, 5'd0, 32'h0);
    set_pipe(1'b1, 1'b0, 5'd3, 32'h0, 32'h33);
    for (int i = 0; i < 4; i++) begin
      e = exp_v(1'b1, 5'd3, 32'h33, 1'b0, 1'b0);
      total++;
      if (obs !== e) begin bad++; $display("FAIL starve_pipe%0d got=%h exp=%h", i, obs, e); end
      tick();
    end
    e = exp_v(1'b1, 5'd7, 32'h77, 1'b1, 1'b0);
    total++;
    if (obs !== e) begin bad++; $display("FAIL starve_force got=%h exp=%h", obs, e); end
    tick();
    e = exp_v(1'b1, 5'd3, 32'h33, 1'b0, 1'b1);
    total++;
    if (obs !== e) begin bad++; $display("FAIL starve_held_write got=%h exp=%h", obs, e); end
    set_pipe(1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
  endtask

  task automatic test_waw();
    logic [`DATAWIDTH+7:0] e;
    set_lu(1'b1, 5'd9, 32'hAA);
    tick();
    set_lu(1'b0, 5'd0, 32'h0);
    set_pipe(1'b1, 1'b0, 5'd9, 32'h0, 32'hBB);
    e = exp_v(1'b1, 5'd9, 32'hBB, 1'b0, 1'b0);
    total++;
    if (obs !== e) begin bad++; $display("FAIL waw_pipe_wins got=%h exp=%h", obs, e); end
    tick();
    set_pipe(1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
    e = exp_v(1'b0, 5'd0, 32'h0, 1'b0, 1'b1);
    total++;
    if (obs !== e) begin bad++; $display("FAIL waw_discarded got=%h exp=%h", obs, e); end
  endtask

  task automatic test_memtoreg();
    logic [`DATAWIDTH+7:0] e;
    set_pipe(1'b1, 1'b1, 5'd2, 32'hDEAD, 32'hBEEF);
    e = exp_v(1'b1, 5'd2, 32'hDEAD, 1'b0, 1'b1);
    total++;
    if (obs !== e) begin bad++; $display("FAIL memtoreg_mem got=%h exp=%h", obs, e); end
    set_pipe(1'b1, 1'b0, 5'd2, 32'hDEAD, 32'hBEEF);
    e = exp_v(1'b1, 5'd2, 32'hBEEF, 1'b0, 1'b1);
    total++;
    if (obs !== e) begin bad++; $display("FAIL memtoreg_alu got=%h exp=%h", obs, e); end
    set_pipe(1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
  endtask

  task automatic test_back_to_back();
    logic [`DATAWIDTH+7:0] e;
    set_lu(1'b1, 5'd4, 32'h44);
    tick();
    set_lu(1'b0, 5'd0, 32'h0);
    set_pipe(1'b1, 1'b1, 5'd8, 32'h88, 32'h0);
    e = exp_v(1'b1, 5'd8, 32'h88, 1'b0, 1'b0);
    total++;
    if (obs !== e) begin bad++; $display("FAIL b2b_pipe got=%h exp=%h", obs, e); end
    tick();
    set_pipe(1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
    e = exp_v(1'b1, 5'd4, 32'h44, 1'b0, 1'b0);
    total++;
    if (obs !== e) begin bad++; $display("FAIL b2b_buffer got=%h exp=%h", obs, e); end
    tick();
  endtask

  task automatic test_reset_in_force();
    logic [`DATAWIDTH+7:0] e;
    set_lu(1'b1, 5'd12, 32'hC0C0);
    tick();
    set_lu(1'b0, 5'd0, 32'h0);
    set_pipe(1'b1, 1'b0, 5'd3, 32'h0, 32'h33);
    tick(); tick(); tick(); tick();
    e = exp_v(1'b1, 5'd12, 32'hC0C0, 1'b1, 1'b0);
    total++;
    if (obs !== e) begin bad++; $display("FAIL rstforce_stall got=%h exp=%h", obs, e); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    set_pipe(1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
    e = exp_v(1'b0, 5'd0, 32'h0, 1'b0, 1'b1);
    total++;
    if (obs !== e) begin bad++; $display("FAIL rstforce_cleared got=%h exp=%h", obs, e); end
    tick();
    total++;
    if (obs !== e) begin bad++; $display("FAIL rstforce_never_written got=%h exp=%h", obs, e); end
  endtask

  initial begin
    test_reset();
    test_free_slot();
    test_drop_x0();
    test_starvation();
    test_waw();
    test_memtoreg();
    test_back_to_back();
    test_reset_in_force();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
